// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 MSB-first full-duplex master, SCLK built from a half-period tick counter
module spi_master_ctrl #(
  parameter int SYS_FREQ  = 50000000,
  parameter int SCLK_FREQ = 1000000,
  parameter int DATA_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o
);
  localparam int HALF = SYS_FREQ / (2 * SCLK_FREQ);
  localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  if (HALF < 2) begin : g_half_chk
    $error("HALF must be at least 2");
  end
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bits;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic accept, tick, last;
  assign ready_o = state == IDLE;
  assign busy_o = ~ready_o;
  assign accept = start_i & ready_o;
  assign tick = ~ready_o & (cnt == CW'(HALF - 1));
  assign last = bits == BW'(DATA_W);
  always_ff @(posedge clk_i or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // after the last fall SCLK stays low one extra half-period in SHIFT, then HOLD
  always_comb begin
    nxt = state;
    if (accept) nxt = SETUP;
    else if (tick)
      nxt = state == SETUP ? SHIFT :
            state == SHIFT ? ((~sclk_o & last) ? HOLD : SHIFT) :
            state == HOLD  ? IDLE : state;
  end
  always_ff @(posedge clk_i or posedge rst)
    if (rst) begin
      cnt <= '0;
      bits <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data_o <= '0;
      done_o <= 1'b0;
      sclk_o <= 1'b0;
      mosi_o <= 1'b0;
      cs_n_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        cnt <= '0;
        bits <= '0;
        tx_sr <= tx_data_i;
        rx_sr <= '0;
        mosi_o <= tx_data_i[DATA_W-1];
        cs_n_o <= 1'b0;
      end else if (~ready_o) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          if (state == HOLD) begin
            cs_n_o <= 1'b1;
            rx_data_o <= rx_sr;
            done_o <= 1'b1;
          end else if (state == SETUP || (state == SHIFT && ~sclk_o && ~last)) begin
            sclk_o <= 1'b1;
            rx_sr <= {rx_sr[DATA_W-2:0], miso_i};
            bits <= bits + 1'b1;
          end else if (state == SHIFT && sclk_o) begin
            sclk_o <= 1'b0;
            if (~last) begin
              mosi_o <= tx_sr[DATA_W-2];
              tx_sr <= tx_sr << 1;
            end
          end
        end
      end
    end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Sequences one SPI mode-0 (CPOL=0, CPHA=0), MSB-first, full-duplex transfer of DATA_W bits per request.
- Generates SCLK as a registered output toggled by an internal half-period tick counter, so no derived clock domain is created.
- Sits between the system-side requester (start/ready/done handshake) and the SPI pins.
- Runs entirely on the 50 MHz system clock.

Parameters:
- SYS_FREQ, 50000000, system clock frequency in Hz.
- SCLK_FREQ, 1000000, desired SCLK frequency in Hz.
- DATA_W, 8, bits per transfer.
- HALF, SYS_FREQ/(2*SCLK_FREQ), system cycles per SCLK half-period. This is a derived value. HALF < 2 is an elaboration error.

Ports:
- clk_i, input, 1, system clock. Single clock domain.
- rst, input, 1, asynchronous active-high reset.
- start_i, input, 1, transfer request. Sampled only while ready_o=1.
- tx_data_i, input, DATA_W, word to send. Captured in the accept cycle.
- ready_o, output, 1, 1 in IDLE. A request is accepted on a cycle where start_i & ready_o.
- busy_o, output, 1, equal to ~ready_o.
- done_o, output, 1, one-cycle pulse when the transfer completes.
- rx_data_o, output, DATA_W, last received word. Held until the next done_o.
- sclk_o, output, 1, SPI clock. Idles low.
- mosi_o, output, 1, SPI data out.
- miso_i, input, 1, SPI data in. Assumed already synchronous to clk_i.
- cs_n_o, output, 1, chip select, active low.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready_o=1, busy_o=0, done_o=0, rx_data_o=0, sclk_o=0, mosi_o=0, cs_n_o=1, internal counters and shift registers=0.
  - Reset mid-transfer aborts the transfer: no done_o, rx_data_o is cleared.
- Tick counter:
  - Cleared on accept.
  - Increments each cycle outside IDLE.
  - tick=1 when cnt==HALF-1, then cnt wraps to 0.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
  - IDLE: on start_i & ready_o, go to SETUP. At the next clock edge:
    - load tx shift register from tx_data_i;
    - cs_n_o=0;
    - mosi_o=tx_data_i[DATA_W-1];
    - ready_o=0;
    - bit count=0.
  - SETUP: sclk_o stays 0. On tick, go to SHIFT and set sclk_o=1 (first rising edge).
  - SHIFT: each tick toggles sclk_o.
    - Rising edge (sclk 0->1): shift miso_i into the rx register LSB (sampled in the tick cycle), and increment the bit count.
    - Falling edge (sclk 1->0): if bit count < DATA_W, present the next tx bit on mosi_o. Otherwise go to HOLD.
    - Exactly DATA_W rising edges occur per transfer.
  - HOLD: sclk_o=0 and mosi_o holds the last bit. On tick, in the same clock edge:
    - cs_n_o=1;
    - rx_data_o=rx register;
    - done_o=1 for one cycle;
    - go to IDLE with ready_o=1.
- Timing:
  - cs_n_o is low for exactly (2*DATA_W+2)*HALF cycles.
  - The first SCLK rise is HALF cycles after cs_n_o falls.
  - SCLK period is 2*HALF cycles, 50% duty.
  - done_o is high in the first cycle with cs_n_o=1.
- Boundary conditions:
  - start_i while busy is ignored (not queued).
  - tx_data_i changes during a transfer have no effect.
  - start_i held high across done_o: the next transfer is accepted in the cycle after done_o. The minimum cs_n_o high time is 1 cycle.
  - rx_data_o and done_o never change outside the HOLD->IDLE edge, except on reset.

Test Plan:
- HALF=2 (SYS_FREQ=8, SCLK_FREQ=2), DATA_W=8. Reset then idle 10 cycles -> cs_n_o=1, sclk_o=0, ready_o=1, done_o=0, rx_data_o=0.
- tx_data_i=8'hA5, miso_i looped to mosi_o, one start pulse:
  - mosi_o sampled on the 8 SCLK rises = 1,0,1,0,0,1,0,1;
  - rx_data_o=8'hA5 at done_o;
  - cs_n_o low for 36 cycles;
  - exactly 8 SCLK rising edges;
  - done_o high for 1 cycle.
- miso_i driven by a slave model returning 8'h3C, tx_data_i=8'hFF -> rx_data_o=8'h3C, mosi_o constant 1 while cs_n_o=0.
- start_i held high for 3 transfers with tx_data_i=8'h01, 8'h80, 8'hFF -> three done_o pulses, cs_n_o high for exactly 1 cycle between transfers, and start_i pulses during busy are ignored.
- Assert rst after the 4th SCLK rise -> cs_n_o=1, sclk_o=0, ready_o=1 immediately (asynchronously), no done_o. A fresh 8'h5A loopback transfer then returns 8'h5A.
- Default parameters (HALF=25), 8'hC3 loopback:
  - SCLK period = 50 cycles, high = 25;
  - cs_n_o low for 450 cycles;
  - rx_data_o=8'hC3.
